alu_wb_stage: RTL

Writeback/commit stage directly downstream of the 16-bit ALU arithmetic units (add/sub). It accepts a result with its ovf and carry outputs, buffers it in a 2-entry FIFO, and presents it to the register-file write port over a valid/ready handshake. It maintains the architectural NZCV status flags and a saturating overflow event counter. Flags update at commit time.

---
 rtl/alu_wb_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
// Writeback/commit stage behind the 16-bit add/sub units: a 2-entry result FIFO
// feeding the register-file write port, plus architectural NZCV flags and an overflow counter.
module alu_wb_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_ovf,
    input  logic              in_carry,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_we,
    input  logic              in_setf,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_we,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic [CNT_W-1:0]  ovf_count
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              ovf;
        logic              carry;
        logic [ADDR_W-1:0] dest;
        logic              we;
        logic              setf;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t     mem_q [2];
    entry_t     in_entry;
    entry_t     head;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    always_comb begin
        // NOTE: assign a default before any field so no path leaves the struct unassigned (latch).
        in_entry        = '0;
        in_entry.result = in_result;
        in_entry.ovf    = in_ovf;
        in_entry.carry  = in_carry;
        in_entry.dest   = in_dest;
        in_entry.we     = in_we;
        in_entry.setf   = in_setf;
    end

    // in_ready deliberately ignores wb_ready: no combinational path from the write port back upstream.
    assign in_ready = !rst && !flush && (count_q != 2'd2);
    assign push     = in_valid && in_ready;
    assign wb_valid = (count_q != 2'd0);
    assign pop      = wb_valid && wb_ready && !rst;

    assign head    = mem_q[rd_ptr_q];
    assign wb_data = head.result;
    assign wb_addr = head.dest;
    assign wb_we   = wb_valid && head.we;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every process sees pre-edge values; never use = here.
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            // NOTE: the storage is reset because wb_data/wb_addr must read zero out of reset.
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A pop in the flush cycle still commits, so flags and counter look only at pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (pop && head.setf) begin
            flag_n <= head.result[DATA_W-1];
            flag_z <= (head.result == '0);
            flag_c <= head.carry;
            flag_v <= head.ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (pop && head.setf && head.ovf && (ovf_count != CNT_MAX)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule
